ram_responder: RTL and testbench
================================

Name: ram_responder

Overview:
- Data-memory responder for the processor's RAM1 port, i.e. the memory end of the RAM1_Address / RAM1_Read_H_Write_L / RAM1_Data_In / RAM1_Data_Out / RAM1_MFC interface.
- Word-addressable on-chip storage with a configurable number of wait states.
- Full four-phase Request/MFC handshake, so the processor's memory stage stalls until the access is complete.
- Sits beside the processor top level in the board wrapper, next to the instruction ROM.

Parameters:
- ADDR_BITS, 8: implemented word-address bits; depth is 2**ADDR_BITS words.
- WAIT_STATES, 2: extra cycles inserted before each access completes; legal range 0..15.
- DATA_WIDTH, 32: word width.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- RAM1_Request  in  1  access request from the processor; held high until MFC is seen.
- RAM1_Address  in  32  word address.
- RAM1_Read_H_Write_L  in  1  1 = read, 0 = write.
- RAM1_Data_In  in  32  write data.
- RAM1_Data_Out  out  32  read data; valid while RAM1_MFC = 1 after a read.
- RAM1_MFC  out  1  memory function complete.
- RAM1_Busy  out  1  high in WAIT and DONE.
- RAM1_Addr_Error  out  1  sticky: set on any access with RAM1_Address[31:ADDR_BITS] != 0.

Behaviour:
- Reset values: RAM1_Data_Out = 0, RAM1_MFC = 0, RAM1_Busy = 0, RAM1_Addr_Error = 0, state = IDLE, wait counter = 0.
- Reset does not clear array contents.
- Reset overrides every state, including mid-access. An in-flight write is discarded and the array is left unmodified.
- States: IDLE, WAIT, DONE.
- IDLE:
  - On an edge with RAM1_Request = 1, latch address, read/write and write data, and load counter = WAIT_STATES. Go to WAIT.
  - Request = 0 means stay in IDLE.
- WAIT:
  - Latched values are used; input changes are ignored.
  - If Request = 0 on an edge: abort. Return to IDLE, perform no access, never assert MFC.
  - Else if counter > 0: decrement.
  - Else (counter = 0): perform the access, set MFC = 1, go to DONE.
- Latency: MFC is first visible after edge e0 + WAIT_STATES + 1, where e0 is the IDLE edge that sampled Request. With WAIT_STATES = 0, MFC rises one cycle after the sampling edge.
- Access on DONE entry:
  - Write: array[addr] <= latched data. RAM1_Data_Out is unchanged.
  - Read: RAM1_Data_Out <= array[addr].
  - Out of range (upper address bits nonzero): the write is suppressed, a read returns 0, and RAM1_Addr_Error is set. MFC is still asserted so the processor never hangs.
- DONE:
  - MFC stays 1 and RAM1_Data_Out is held while Request = 1.
  - On the first edge with Request = 0, MFC <= 0 and state goes to IDLE.
  - A new request is accepted no earlier than the edge after the return to IDLE. Request must be seen low for at least one edge between accesses.
- RAM1_Data_Out retains its last read value outside DONE.
- RAM1_Addr_Error clears only on Reset.
- Simultaneous Reset and Request: Reset wins; the request is not latched.

Decomposition:
- Shared package ram_pkg:
  - state enum {IDLE, WAIT, DONE}.
  - RW_READ = 1, RW_WRITE = 0.
  - MAX_WAIT_STATES = 15.
- Sub-module ram_word_array: single-port synchronous array with parameters DATA_WIDTH and ADDR_BITS. Ports: Clock, we, addr, wdata, rdata (registered read).
- ram_responder contains the FSM, the latches, the wait counter and range checking.

Test Plan:
- Write, WAIT_STATES = 2: Request = 1, Address = 0x10, RW = 0, Data_In = 0xDEADBEEF. Required: MFC rises exactly 3 edges after the sampling edge; Busy is high throughout. Drop Request: MFC = 0 one edge later, state returns to IDLE.
- Read-back: read 0x10. Required: Data_Out = 0xDEADBEEF when MFC rises, held until Request drops. An unwritten word read after reset returns the array's initial value, which the bench loads as 0.
- WAIT_STATES = 0 back-to-back: write 0x1 to address 3, Request low for one cycle, then read address 3. Required: each MFC rises one cycle after its sampling edge; the read returns 0x00000001.
- Abort: start a write of 0x55 to address 7, drop Request during WAIT. Required: MFC never asserts. A later read of address 7 returns its prior value of 0.
- Out of range: write 0xFFFF to address 0x100 (ADDR_BITS = 8). Required: Addr_Error = 1, MFC asserts, address 0x00 unchanged. Read 0x100: Data_Out = 0.
- Reset mid-access: assert Reset during WAIT of a write to address 2 with 0xAA. Required: next cycle MFC = 0, Busy = 0, Data_Out = 0. A subsequent read of address 2 returns its old contents.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and constants for the RAM1 data-memory responder.
package ram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam int MAX_WAIT_STATES = 15;

endpackage

// File: rtl/ram_word_array.sv
// Single-port word array: synchronous write, registered read of the addressed word.
module ram_word_array #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 8
) (
    input  logic                  Clock,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_BITS];

    // No reset: contents survive Reset by design.
    always_ff @(posedge Clock) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata <= mem_q[addr];
    end

endmodule

// File: rtl/ram_responder.sv
// RAM1 responder: four-phase Request/MFC handshake in front of a word array,
// with a programmable number of wait states and sticky out-of-range flag.
module ram_responder
    import ram_pkg::*;
#(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_STATES = 2,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  RAM1_Request,
    input  logic [31:0]           RAM1_Address,
    input  logic                  RAM1_Read_H_Write_L,
    input  logic [DATA_WIDTH-1:0] RAM1_Data_In,
    output logic [DATA_WIDTH-1:0] RAM1_Data_Out,
    output logic                  RAM1_MFC,
    output logic                  RAM1_Busy,
    output logic                  RAM1_Addr_Error
);

    localparam int WS_CLAMP = (WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES : WAIT_STATES;
    localparam logic [3:0] WS_LOAD = 4'(WS_CLAMP);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [31:0]           addr_q, addr_d;
    logic                  rw_q, rw_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  mfc_q, mfc_d;
    logic                  err_q, err_d;

    logic                  we_c;
    logic                  in_range;
    logic [ADDR_BITS-1:0]  arr_addr;
    logic [DATA_WIDTH-1:0] arr_rdata;

    assign in_range = (addr_q[31:ADDR_BITS] == '0);

    // In IDLE the array sees the live address so the registered read is
    // already valid when a zero-wait-state access completes one edge later.
    assign arr_addr = (state_q == IDLE) ? RAM1_Address[ADDR_BITS-1:0]
                                        : addr_q[ADDR_BITS-1:0];

    ram_word_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (ADDR_BITS)
    ) u_array (
        .Clock (Clock),
        .we    (we_c & ~Reset),
        .addr  (arr_addr),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        mfc_d   = mfc_q;
        err_d   = err_q;
        we_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (RAM1_Request) begin
                    addr_d  = RAM1_Address;
                    rw_d    = RAM1_Read_H_Write_L;
                    wdata_d = RAM1_Data_In;
                    cnt_d   = WS_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!RAM1_Request) begin
                    state_d = IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                    mfc_d   = 1'b1;
                    if (!in_range) begin
                        err_d = 1'b1;
                        if (rw_q == RW_READ) begin
                            dout_d = '0;
                        end
                    end else if (rw_q == RW_READ) begin
                        dout_d = arr_rdata;
                    end else begin
                        we_c = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!RAM1_Request) begin
                    mfc_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            rw_q    <= RW_READ;
            wdata_q <= '0;
            dout_q  <= '0;
            mfc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            mfc_q   <= mfc_d;
            err_q   <= err_d;
        end
    end

    assign RAM1_Data_Out   = dout_q;
    assign RAM1_MFC        = mfc_q;
    assign RAM1_Busy       = (state_q == WAIT) || (state_q == DONE);
    assign RAM1_Addr_Error = err_q;

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: one instance with 2 wait states, one with 0,
// driven by directed accesses; Data_Out at each MFC rise is scoreboarded.
module tb_ram_responder;

    logic        clk;
    logic        rst   [2];
    logic        req   [2];
    logic [31:0] addr  [2];
    logic        rw    [2];
    logic [31:0] din   [2];
    logic [31:0] dout  [2];
    logic        mfc   [2];
    logic        busy  [2];
    logic        err   [2];

    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    logic [31:0] last_rd [2];
    logic        mfc_prev [2];

    int checks;
    int failures;

    ram_responder #(.ADDR_BITS(8), .WAIT_STATES(2), .DATA_WIDTH(32)) dut_ws2 (
        .Clock               (clk),
        .Reset               (rst[0]),
        .RAM1_Request        (req[0]),
        .RAM1_Address        (addr[0]),
        .RAM1_Read_H_Write_L (rw[0]),
        .RAM1_Data_In        (din[0]),
        .RAM1_Data_Out       (dout[0]),
        .RAM1_MFC            (mfc[0]),
        .RAM1_Busy           (busy[0]),
        .RAM1_Addr_Error     (err[0])
    );

    ram_responder #(.ADDR_BITS(8), .WAIT_STATES(0), .DATA_WIDTH(32)) dut_ws0 (
        .Clock               (clk),
        .Reset               (rst[1]),
        .RAM1_Request        (req[1]),
        .RAM1_Address        (addr[1]),
        .RAM1_Read_H_Write_L (rw[1]),
        .RAM1_Data_In        (din[1]),
        .RAM1_Data_Out       (dout[1]),
        .RAM1_MFC            (mfc[1]),
        .RAM1_Busy           (busy[1]),
        .RAM1_Addr_Error     (err[1])
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (act=running req=finished)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, expv);
        end
    endtask

    // Monitor: every MFC rising edge pops one expected Data_Out
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mfc[i] && !mfc_prev[i]) begin
                checks++;
                if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
                    failures++;
                    $display("FAIL unexpected_mfc inst%0d: actual=mfc_rise required=none", i);
                end else begin
                    logic [31:0] e;
                    e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    if (dout[i] !== e) begin
                        failures++;
                        $display("FAIL data_out inst%0d: actual=0x%08h required=0x%08h", i, dout[i], e);
                    end
                end
            end
            mfc_prev[i] = mfc[i];
        end
    end

    // Driver: one complete four-phase access
    task automatic do_access(input int inst, input logic [31:0] a, input logic is_rd,
                             input logic [31:0] wd, input logic [31:0] rd_exp);
        int k;
        int ws;
        logic busy_ok;
        logic [31:0] exp_out;
        ws = (inst == 0) ? 2 : 0;
        exp_out = is_rd ? rd_exp : last_rd[inst];
        if (is_rd) last_rd[inst] = rd_exp;
        if (inst == 0) exp_q0.push_back(exp_out);
        else           exp_q1.push_back(exp_out);
        @(negedge clk);
        req[inst] = 1'b1; addr[inst] = a; rw[inst] = is_rd; din[inst] = wd;
        @(posedge clk);
        k = 0;
        busy_ok = 1'b1;
        do begin
            @(posedge clk); #1;
            k++;
            if (!busy[inst]) busy_ok = 1'b0;
        end while (!mfc[inst] && k < 20);
        chk($sformatf("latency inst%0d", inst), k, ws + 1);
        chk($sformatf("busy_in_access inst%0d", inst), {31'd0, busy_ok}, 32'd1);
        // Latched values must be used; scramble inputs while holding Request
        addr[inst] = 32'h0000_00FF; din[inst] = 32'h0BAD_0BAD; rw[inst] = ~is_rd;
        repeat (2) @(posedge clk);
        #1;
        chk($sformatf("mfc_hold inst%0d", inst), {31'd0, mfc[inst]}, 32'd1);
        chk($sformatf("dout_hold inst%0d", inst), dout[inst], exp_out);
        @(negedge clk);
        req[inst] = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("mfc_drop inst%0d", inst), {31'd0, mfc[inst]}, 32'd0);
        chk($sformatf("busy_idle inst%0d", inst), {31'd0, busy[inst]}, 32'd0);
    endtask

    initial begin
        logic [31:0] preload_addrs [6];
        checks = 0;
        failures = 0;
        preload_addrs = '{32'h10, 32'h20, 32'h7, 32'h2, 32'h0, 32'h3};
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; req[i] = 1'b0; addr[i] = 32'd0; rw[i] = 1'b1;
            din[i] = 32'd0; last_rd[i] = 32'd0; mfc_prev[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;

        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset_dout inst%0d", i), dout[i], 32'd0);
            chk($sformatf("reset_mfc inst%0d", i), {31'd0, mfc[i]}, 32'd0);
            chk($sformatf("reset_busy inst%0d", i), {31'd0, busy[i]}, 32'd0);
            chk($sformatf("reset_err inst%0d", i), {31'd0, err[i]}, 32'd0);
        end

        // Bench-defined initial array contents: zero the words used below
        for (int i = 0; i < 2; i++)
            foreach (preload_addrs[j]) do_access(i, preload_addrs[j], 1'b0, 32'd0, 32'd0);

        // WAIT_STATES = 2: write, read-back, unwritten word
        do_access(0, 32'h10, 1'b0, 32'hDEAD_BEEF, 32'd0);
        do_access(0, 32'h10, 1'b1, 32'd0, 32'hDEAD_BEEF);
        do_access(0, 32'h20, 1'b1, 32'd0, 32'h0);

        // Abort during WAIT: no MFC, no write
        @(negedge clk);
        req[0] = 1'b1; addr[0] = 32'h7; rw[0] = 1'b0; din[0] = 32'h55;
        @(posedge clk);
        @(negedge clk);
        req[0] = 1'b0;
        begin
            logic saw_mfc;
            saw_mfc = 1'b0;
            repeat (6) begin
                @(posedge clk); #1;
                if (mfc[0]) saw_mfc = 1'b1;
            end
            chk("abort_no_mfc", {31'd0, saw_mfc}, 32'd0);
            chk("abort_busy", {31'd0, busy[0]}, 32'd0);
        end
        do_access(0, 32'h7, 1'b1, 32'd0, 32'h0);

        // Reset on the edge that would complete a write to address 2
        do_access(0, 32'h2, 1'b0, 32'h1234_5678, 32'd0);
        do_access(0, 32'h10, 1'b1, 32'd0, 32'hDEAD_BEEF);
        @(negedge clk);
        req[0] = 1'b1; addr[0] = 32'h2; rw[0] = 1'b0; din[0] = 32'hAA;
        @(posedge clk);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst[0] = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_mfc", {31'd0, mfc[0]}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy[0]}, 32'd0);
        chk("rst_mid_dout", dout[0], 32'd0);
        @(negedge clk);
        rst[0] = 1'b0; req[0] = 1'b0;
        last_rd[0] = 32'd0;
        do_access(0, 32'h2, 1'b1, 32'd0, 32'h1234_5678);

        // Out of range
        do_access(0, 32'h100, 1'b0, 32'h0000_FFFF, 32'd0);
        chk("addr_err_set", {31'd0, err[0]}, 32'd1);
        do_access(0, 32'h0, 1'b1, 32'd0, 32'h0);
        do_access(0, 32'h10, 1'b1, 32'd0, 32'hDEAD_BEEF);
        do_access(0, 32'h100, 1'b1, 32'd0, 32'h0);
        chk("addr_err_sticky", {31'd0, err[0]}, 32'd1);
        chk("addr_err_other_inst", {31'd0, err[1]}, 32'd0);

        // WAIT_STATES = 0 back-to-back
        do_access(1, 32'h3, 1'b0, 32'h1, 32'd0);
        do_access(1, 32'h3, 1'b1, 32'd0, 32'h1);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty inst0", exp_q0.size(), 32'd0);
        chk("scoreboard_empty inst1", exp_q1.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
